// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - requester/write-port bundle for the write-back arbiter
//
// Purpose: groups the policy controls, both requester channels and the
// registered register-file write port into one bundle.
//
// Signals:
//   mode            0 = round-robin, 1 = fixed priority A with aging for B
//   stall           register-file port busy; no grants while high
//   req_a/addr_a/data_a   requester A (ALU result path), held until granted
//   req_b/addr_b/data_b   requester B (load/memory path), held until granted
//   gnt_a/gnt_b     combinational one-hot grants
//   wr_en/wr_addr/wr_data registered register-file write
//   last_b          registered; 1 when the most recent grant went to B
//
// Modports: master = execute/memory side (drives requests, sees grants and
// the write port), slave = the arbiter.

interface wb_port_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              mode;
   logic              stall;
   logic              req_a;
   logic [ADDR_W-1:0] addr_a;
   logic [DATA_W-1:0] data_a;
   logic              req_b;
   logic [ADDR_W-1:0] addr_b;
   logic [DATA_W-1:0] data_b;
   logic              gnt_a;
   logic              gnt_b;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              last_b;

   modport master (
      output mode, stall,
      output req_a, addr_a, data_a,
      output req_b, addr_b, data_b,
      input  gnt_a, gnt_b,
      input  wr_en, wr_addr, wr_data, last_b
   );

   modport slave (
      input  mode, stall,
      input  req_a, addr_a, data_a,
      input  req_b, addr_b, data_b,
      output gnt_a, gnt_b,
      output wr_en, wr_addr, wr_data, last_b
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - two-requester arbiter for the register-file write port
//
// Purpose: picks one of two write-back requesters (A = ALU result, B = load
// path) each cycle, steers the 2:1 write-data mux with the B grant and
// registers the winner into a one-cycle register-file write.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    wb_port_arbiter_if.slave: mode, stall, both request channels in;
//          combinational grants, registered wr_en/wr_addr/wr_data, last_b out
//
// Policies:
//   mode=0  round-robin; the pointer names the side that wins a tie and
//           moves to the losing side after every grant.
//   mode=1  A wins ties unless B has waited MAX_WAIT consecutive unstalled
//           cycles, in which case B is forced ahead.
// Pointer and aging counter keep running in both modes, so switching
// policy never resets either of them.

module wb_port_arbiter #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int MAX_WAIT = 4,
   parameter int WAIT_W   = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   wb_port_arbiter_if.slave      bus
);

   localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

   // Round-robin pointer: 0 names A, 1 names B.
   logic              rr_ptr_b;
   // Consecutive ungranted, unstalled cycles of req_b.
   logic [WAIT_W-1:0] wait_cnt;

   logic              pick_rr_b;
   logic              pick_fp_b;
   logic              pick_b;
   logic              gnt_a_c;
   logic              gnt_b_c;
   logic              any_gnt;
   logic              aged;

   logic [ADDR_W-1:0] mux_addr;
   logic [DATA_W-1:0] mux_data;

   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic              last_b_q;

   // ------------------------------------------------------------------
   // Grant selection
   // ------------------------------------------------------------------
   assign aged = (wait_cnt == WAIT_SAT);

   always_comb begin
      pick_rr_b = 1'b0;
      pick_fp_b = 1'b0;
      pick_b    = 1'b0;
      gnt_a_c   = 1'b0;
      gnt_b_c   = 1'b0;

      // B is chosen when it is the only requester, or on a tie when the
      // active policy favours it.
      pick_rr_b = bus.req_b & (~bus.req_a | rr_ptr_b);
      pick_fp_b = bus.req_b & (~bus.req_a | aged);
      pick_b    = bus.mode ? pick_fp_b : pick_rr_b;

      // Reset and stall gate both grants; the A grant is the complement of
      // the B pick so the pair can never be high together.
      if (rst_n && !bus.stall) begin
         gnt_b_c = pick_b;
         gnt_a_c = bus.req_a & ~pick_b;
      end
   end

   assign any_gnt   = gnt_a_c | gnt_b_c;
   assign bus.gnt_a = gnt_a_c;
   assign bus.gnt_b = gnt_b_c;

   // Write-data / address mux, selected by the B grant.
   assign mux_addr = gnt_b_c ? bus.addr_b : bus.addr_a;
   assign mux_data = gnt_b_c ? bus.data_b : bus.data_a;

   // ------------------------------------------------------------------
   // Round-robin pointer
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_b <= 1'b0;
      end else if (any_gnt) begin
         // Point at the side that just lost (or was idle).
         rr_ptr_b <= gnt_a_c;
      end
   end

   // ------------------------------------------------------------------
   // Aging counter for B
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (bus.stall) begin
         // Stalled cycles are not counted as waiting.
         wait_cnt <= wait_cnt;
      end else if (gnt_b_c || !bus.req_b) begin
         wait_cnt <= '0;
      end else if (!aged) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Registered write port
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         last_b_q  <= 1'b0;
      end else if (any_gnt) begin
         // Register 0 is hard-wired: the request is consumed but no write
         // strobe is produced.
         wr_en_q   <= (mux_addr != '0);
         wr_addr_q <= mux_addr;
         wr_data_q <= mux_data;
         last_b_q  <= gnt_b_c;
      end else begin
         wr_en_q   <= 1'b0;
      end
   end

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign bus.last_b  = last_b_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter

module tb_wb_port_arbiter;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   wb_port_arbiter #(
      .DATA_W   (32),
      .ADDR_W   (5),
      .MAX_WAIT (4),
      .WAIT_W   (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic idle_inputs();
      bus.mode   = 1'b0;
      bus.stall  = 1'b0;
      bus.req_a  = 1'b0;
      bus.addr_a = '0;
      bus.data_a = '0;
      bus.req_b  = 1'b0;
      bus.addr_b = '0;
      bus.data_b = '0;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      bus.req_a  = 1'b1;
      bus.addr_a = 5'd1;
      bus.data_a = 32'h11;
      bus.req_b  = 1'b1;
      bus.addr_b = 5'd2;
      bus.data_b = 32'h22;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         n_cmp++; if (bus.gnt_a !== 1'b0) begin n_bad++; $display("FAIL reset_gnt_a cyc%0d got %b want 0", i, bus.gnt_a); end
         n_cmp++; if (bus.gnt_b !== 1'b0) begin n_bad++; $display("FAIL reset_gnt_b cyc%0d got %b want 0", i, bus.gnt_b); end
         n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en cyc%0d got %b want 0", i, bus.wr_en); end
         n_cmp++; if (bus.wr_addr !== 5'd0) begin n_bad++; $display("FAIL reset_wr_addr cyc%0d got %0d want 0", i, bus.wr_addr); end
         n_cmp++; if (bus.wr_data !== 32'd0) begin n_bad++; $display("FAIL reset_wr_data cyc%0d got %h want 0", i, bus.wr_data); end
         n_cmp++; if (bus.last_b !== 1'b0) begin n_bad++; $display("FAIL reset_last_b cyc%0d got %b want 0", i, bus.last_b); end
      end
      rst_n = 1'b1;
      #1;
      n_cmp++; if (bus.gnt_a !== 1'b1) begin n_bad++; $display("FAIL reset_first_gnt_a got %b want 1", bus.gnt_a); end
      n_cmp++; if (bus.gnt_b !== 1'b0) begin n_bad++; $display("FAIL reset_first_gnt_b got %b want 0", bus.gnt_b); end
      @(posedge clk); #1;
      n_cmp++; if (bus.wr_en !== 1'b1) begin n_bad++; $display("FAIL reset_first_wr_en got %b want 1", bus.wr_en); end
      n_cmp++; if (bus.wr_addr !== 5'd1) begin n_bad++; $display("FAIL reset_first_wr_addr got %0d want 1", bus.wr_addr); end
      n_cmp++; if (bus.wr_data !== 32'h11) begin n_bad++; $display("FAIL reset_first_wr_data got %h want 11", bus.wr_data); end
      bus.req_a = 1'b0;
      bus.req_b = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_idle_wr_en got %b want 0", bus.wr_en); end
   endtask

   // Pointer names B after the reset test; a lone B request must still win.
   task automatic test_single_requester();
      bus.mode   = 1'b0;
      bus.req_b  = 1'b1;
      bus.addr_b = 5'd9;
      bus.data_b = 32'd555;
      #1;
      n_cmp++; if (bus.gnt_b !== 1'b1) begin n_bad++; $display("FAIL single_gnt_b got %b want 1", bus.gnt_b); end
      n_cmp++; if (bus.gnt_a !== 1'b0) begin n_bad++; $display("FAIL single_gnt_a got %b want 0", bus.gnt_a); end
      @(posedge clk); #1;
      n_cmp++; if (bus.wr_en !== 1'b1) begin n_bad++; $display("FAIL single_wr_en got %b want 1", bus.wr_en); end
      n_cmp++; if (bus.wr_addr !== 5'd9) begin n_bad++; $display("FAIL single_wr_addr got %0d want 9", bus.wr_addr); end
      n_cmp++; if (bus.wr_data !== 32'd555) begin n_bad++; $display("FAIL single_wr_data got %0d want 555", bus.wr_data); end
      n_cmp++; if (bus.last_b !== 1'b1) begin n_bad++; $display("FAIL single_last_b got %b want 1", bus.last_b); end
   endtask

   // Pointer now names A: expect A,B,A,B back to back.
   task automatic test_round_robin();
      logic exp_b;
      bus.mode   = 1'b0;
      bus.req_a  = 1'b1;
      bus.addr_a = 5'd3;
      bus.data_a = 32'd4;
      bus.req_b  = 1'b1;
      bus.addr_b = 5'd7;
      bus.data_b = 32'd12;
      for (int i = 0; i < 4; i++) begin
         exp_b = (i % 2) == 1;
         #1;
         n_cmp++; if (bus.gnt_a !== !exp_b) begin n_bad++; $display("FAIL rr_gnt_a cyc%0d got %b want %b", i, bus.gnt_a, !exp_b); end
         n_cmp++; if (bus.gnt_b !== exp_b) begin n_bad++; $display("FAIL rr_gnt_b cyc%0d got %b want %b", i, bus.gnt_b, exp_b); end
         @(posedge clk); #1;
         n_cmp++; if (bus.wr_en !== 1'b1) begin n_bad++; $display("FAIL rr_wr_en cyc%0d got %b want 1", i, bus.wr_en); end
         n_cmp++; if (bus.wr_addr !== (exp_b ? 5'd7 : 5'd3)) begin n_bad++; $display("FAIL rr_wr_addr cyc%0d got %0d want %0d", i, bus.wr_addr, exp_b ? 7 : 3); end
         n_cmp++; if (bus.wr_data !== (exp_b ? 32'd12 : 32'd4)) begin n_bad++; $display("FAIL rr_wr_data cyc%0d got %0d want %0d", i, bus.wr_data, exp_b ? 12 : 4); end
         n_cmp++; if (bus.last_b !== exp_b) begin n_bad++; $display("FAIL rr_last_b cyc%0d got %b want %b", i, bus.last_b, exp_b); end
      end
      bus.req_a = 1'b0;
      bus.req_b = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL rr_idle_wr_en got %b want 0", bus.wr_en); end
      n_cmp++; if (bus.wr_addr !== 5'd7) begin n_bad++; $display("FAIL rr_hold_addr got %0d want 7", bus.wr_addr); end
      n_cmp++; if (bus.wr_data !== 32'd12) begin n_bad++; $display("FAIL rr_hold_data got %0d want 12", bus.wr_data); end
   endtask

   // Reset asserted while A is requesting drops the transfer.
   task automatic test_reset_midflight();
      bus.req_a  = 1'b1;
      bus.addr_a = 5'd3;
      bus.data_a = 32'd4;
      rst_n      = 1'b0;
      #1;
      n_cmp++; if (bus.gnt_a !== 1'b0) begin n_bad++; $display("FAIL midrst_gnt_a got %b want 0", bus.gnt_a); end
      @(posedge clk); #1;
      n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL midrst_wr_en got %b want 0", bus.wr_en); end
      n_cmp++; if (bus.wr_addr !== 5'd0) begin n_bad++; $display("FAIL midrst_wr_addr got %0d want 0", bus.wr_addr); end
      n_cmp++; if (bus.wr_data !== 32'd0) begin n_bad++; $display("FAIL midrst_wr_data got %0d want 0", bus.wr_data); end
      bus.req_a = 1'b0;
      rst_n     = 1'b1;
      @(posedge clk); #1;
   endtask

   // Fixed priority: 2 A grants (counter 2), 3 stalled cycles (counter
   // frozen at 2), then A,A (counter 3,4), B forced, A.
   task automatic test_stall();
      logic [8:0] stall_pat;
      logic [8:0] b_pat;
      logic       exp_a;
      logic       exp_b;
      logic [4:0] hold_addr;
      logic [31:0] hold_data;
      logic       hold_last_b;
      stall_pat  = 9'b0_0001_1100;
      b_pat      = 9'b0_1000_0000;
      hold_addr  = 5'd7;
      hold_data  = 32'd12;
      hold_last_b = 1'b0;
      bus.mode   = 1'b1;
      bus.req_a  = 1'b1;
      bus.addr_a = 5'd5;
      bus.data_a = 32'hA5A5;
      bus.req_b  = 1'b1;
      bus.addr_b = 5'd6;
      bus.data_b = 32'hB6B6;
      hold_addr  = 5'd0;
      hold_data  = 32'd0;
      for (int i = 0; i < 9; i++) begin
         bus.stall = stall_pat[i];
         exp_b = b_pat[i];
         exp_a = !stall_pat[i] && !b_pat[i];
         #1;
         n_cmp++; if (bus.gnt_a !== exp_a) begin n_bad++; $display("FAIL stall_gnt_a cyc%0d got %b want %b", i, bus.gnt_a, exp_a); end
         n_cmp++; if (bus.gnt_b !== exp_b) begin n_bad++; $display("FAIL stall_gnt_b cyc%0d got %b want %b", i, bus.gnt_b, exp_b); end
         if (exp_a) begin hold_addr = 5'd5; hold_data = 32'hA5A5; hold_last_b = 1'b0; end
         if (exp_b) begin hold_addr = 5'd6; hold_data = 32'hB6B6; hold_last_b = 1'b1; end
         @(posedge clk); #1;
         n_cmp++; if (bus.wr_en !== (exp_a | exp_b)) begin n_bad++; $display("FAIL stall_wr_en cyc%0d got %b want %b", i, bus.wr_en, exp_a | exp_b); end
         n_cmp++; if (bus.wr_addr !== hold_addr) begin n_bad++; $display("FAIL stall_wr_addr cyc%0d got %0d want %0d", i, bus.wr_addr, hold_addr); end
         n_cmp++; if (bus.wr_data !== hold_data) begin n_bad++; $display("FAIL stall_wr_data cyc%0d got %h want %h", i, bus.wr_data, hold_data); end
         n_cmp++; if (bus.last_b !== hold_last_b) begin n_bad++; $display("FAIL stall_last_b cyc%0d got %b want %b", i, bus.last_b, hold_last_b); end
      end
      bus.stall = 1'b0;
      bus.req_a = 1'b0;
      bus.req_b = 1'b0;
      @(posedge clk); #1;
   endtask

   // Fixed priority from a cleared counter: B wins on cycles 4 and 9.
   task automatic test_aging();
      logic [9:0] b_pat;
      logic       exp_b;
      b_pat      = 10'b10_0001_0000;
      bus.mode   = 1'b1;
      bus.req_a  = 1'b1;
      bus.addr_a = 5'd5;
      bus.data_a = 32'hA5A5;
      bus.req_b  = 1'b1;
      bus.addr_b = 5'd6;
      bus.data_b = 32'hB6B6;
      for (int i = 0; i < 10; i++) begin
         exp_b = b_pat[i];
         #1;
         n_cmp++; if (bus.gnt_a !== !exp_b) begin n_bad++; $display("FAIL aging_gnt_a cyc%0d got %b want %b", i, bus.gnt_a, !exp_b); end
         n_cmp++; if (bus.gnt_b !== exp_b) begin n_bad++; $display("FAIL aging_gnt_b cyc%0d got %b want %b", i, bus.gnt_b, exp_b); end
         @(posedge clk); #1;
         n_cmp++; if (bus.wr_addr !== (exp_b ? 5'd6 : 5'd5)) begin n_bad++; $display("FAIL aging_wr_addr cyc%0d got %0d want %0d", i, bus.wr_addr, exp_b ? 6 : 5); end
         n_cmp++; if (bus.wr_data !== (exp_b ? 32'hB6B6 : 32'hA5A5)) begin n_bad++; $display("FAIL aging_wr_data cyc%0d got %h", i, bus.wr_data); end
      end
      n_cmp++; if (bus.last_b !== 1'b1) begin n_bad++; $display("FAIL aging_last_b got %b want 1", bus.last_b); end
      bus.req_a = 1'b0;
      bus.req_b = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_zero_register();
      bus.mode   = 1'b0;
      bus.req_a  = 1'b1;
      bus.addr_a = 5'd0;
      bus.data_a = 32'd1;
      #1;
      n_cmp++; if (bus.gnt_a !== 1'b1) begin n_bad++; $display("FAIL zero_gnt_a got %b want 1", bus.gnt_a); end
      @(posedge clk); #1;
      n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL zero_wr_en got %b want 0", bus.wr_en); end
      n_cmp++; if (bus.last_b !== 1'b0) begin n_bad++; $display("FAIL zero_last_b got %b want 0", bus.last_b); end
      bus.addr_a = 5'd2;
      bus.data_a = 32'd7;
      #1;
      n_cmp++; if (bus.gnt_a !== 1'b1) begin n_bad++; $display("FAIL zero_next_gnt_a got %b want 1", bus.gnt_a); end
      @(posedge clk); #1;
      n_cmp++; if (bus.wr_en !== 1'b1) begin n_bad++; $display("FAIL zero_next_wr_en got %b want 1", bus.wr_en); end
      n_cmp++; if (bus.wr_addr !== 5'd2) begin n_bad++; $display("FAIL zero_next_wr_addr got %0d want 2", bus.wr_addr); end
      n_cmp++; if (bus.wr_data !== 32'd7) begin n_bad++; $display("FAIL zero_next_wr_data got %0d want 7", bus.wr_data); end
      bus.req_a = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL zero_idle_wr_en got %b want 0", bus.wr_en); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_single_requester();
      test_round_robin();
      test_reset_midflight();
      test_stall();
      test_aging();
      test_zero_register();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Arbitrates two write-back requesters (A = ALU result path, B = load/memory path) onto the single 32-bit register-file write port.
- Drives the select of the 32-bit two-to-one write-data mux internally, with round-robin or fixed-priority-with-aging policy.
- Registers the winning address and data into a one-cycle write pulse.
- Sits between the execute/memory stages and the register file.

Parameters:
- DATA_W, 32, write-data width.
- ADDR_W, 5, register address width.
- MAX_WAIT, 4, in fixed-priority mode: consecutive ungranted, unstalled cycles of REQ_B before B is forced ahead of A (range 1..7).
- WAIT_W, 3, width of the aging counter; must hold MAX_WAIT.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  synchronous reset, active low; sampled on rising CLK.
- MODE  in  1  0 = round-robin, 1 = fixed priority A with aging for B.
- STALL  in  1  register-file port busy; no grants while high.
- REQ_A  in  1  requester A valid; held with ADDR_A/DATA_A until granted.
- ADDR_A  in  ADDR_W  destination register, A.
- DATA_A  in  DATA_W  write data, A.
- REQ_B  in  1  requester B valid; same rules as A.
- ADDR_B  in  ADDR_W  destination register, B.
- DATA_B  in  DATA_W  write data, B.
- GNT_A  out  1  combinational grant; transfer when REQ_A & GNT_A at rising edge.
- GNT_B  out  1  combinational grant, B.
- WR_EN  out  1  registered register-file write strobe.
- WR_ADDR  out  ADDR_W  registered write address.
- WR_DATA  out  DATA_W  registered write data (mux output).
- LAST_B  out  1  registered; 1 if the most recent grant went to B.

Behaviour:
- Reset (RST_N=0 at edge): WR_EN=0, WR_ADDR=0, WR_DATA=0, LAST_B=0, RR pointer=A, wait counter=0. GNT_A and GNT_B forced 0 combinationally while RST_N=0. Reset mid-transfer drops that transfer; no write issues.
- Grants are one-hot, never both high. No grant while STALL=1 or when the selected REQ is 0.
- Mux select is GNT_B: WR_DATA/WR_ADDR take the B inputs when GNT_B, otherwise the A inputs.
- Latency: a grant at edge t gives WR_EN=1 in cycle t+1 with that address and data. Otherwise WR_EN=0 next cycle, and WR_ADDR/WR_DATA hold their previous values.
- Address 0 is the hard-wired zero register: a request with ADDR=0 is still granted (consumed), but the WR_EN produced is 0.
- MODE=0, round-robin:
  - Only one requester: that requester is granted.
  - Both requesting: grant the one the pointer names.
  - The pointer moves to the non-granted side after every grant, and holds when there is no grant.
- MODE=1, fixed priority:
  - A wins ties unless wait counter == MAX_WAIT, in which case B wins.
  - Counter increments (saturating at MAX_WAIT) each cycle REQ_B=1, STALL=0 and GNT_B=0.
  - Counter clears on GNT_B or when REQ_B=0. It holds while STALL=1.
- MODE is sampled per cycle; switching policy does not reset the pointer or the counter.
- LAST_B updates only on a grant: 1 for B, 0 for A.
- Bursts: back-to-back grants every cycle are allowed, so throughput is one write per cycle.

Test Plan:
- Reset: RST_N=0 for 2 cycles with REQ_A=REQ_B=1 -> GNT_A=GNT_B=0, WR_EN=0, WR_ADDR=0, WR_DATA=0. Release -> first grant goes to A (pointer=A).
- Round-robin: MODE=0, REQ_A (addr 3, data 4) and REQ_B (addr 7, data 12) held high for 4 cycles -> grants A,B,A,B; WR outputs one cycle later: (3,4),(7,12),(3,4),(7,12).
- Single requester: MODE=0, REQ_B only (addr 9, data 555) -> GNT_B same cycle; next cycle WR_EN=1, WR_ADDR=9, WR_DATA=555; pointer then names A.
- Aging: MODE=1, MAX_WAIT=4, REQ_A and REQ_B held high -> A granted 4 cycles, B granted on the 5th, then A again; counter observed cleared after the B grant.
- Stall: both requesting, STALL=1 for 3 cycles -> no grants, WR_EN=0, wait counter frozen. STALL falls -> arbitration resumes with the same pointer/counter.
- Zero register: REQ_A with ADDR_A=0, DATA_A=1 -> GNT_A=1; next cycle WR_EN=0. Then REQ_A with ADDR_A=2, DATA_A=7 -> WR_EN=1, WR_ADDR=2, WR_DATA=7.
